// File: rtl/fib_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_ram_ctrl_pkg
// Description : Shared constants and state encoding for the Fibonacci RAM
//               sequencer (fib_ram_ctrl) and its adder (fib_add_sat).
// Revision    : 1.0 - initial release
// ============================================================================
package fib_ram_ctrl_pkg;

    // Default datapath and address widths
    localparam int c_data_w_def = 32;
    localparam int c_addr_w_def = 6;

    // Sequencer states, one cycle each
    typedef enum logic [2:0] {
        c_st_idle  = 3'd0,
        c_st_rd_a  = 3'd1,
        c_st_rd_b  = 3'd2,
        c_st_cap_b = 3'd3,
        c_st_wr    = 3'd4,
        c_st_fin   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fib_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : fib_add_sat
// Description : DATA_W-bit adder for the Fibonacci sequencer. By default the
//               sum wraps modulo 2**DATA_W. With macro FIB_SAT_EN defined, a
//               carry-out clamps the sum to all-ones and raises o_sat.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_add_sat
    import fib_ram_ctrl_pkg::*;
#(
    parameter int DATA_W = c_data_w_def
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_sat
);

`ifdef FIB_SAT_EN
    logic [DATA_W:0] w_full;

    // Widened add; a carry-out saturates the result
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b};
        if (w_full[DATA_W]) begin
            o_sum = '1;
            o_sat = 1'b1;
        end else begin
            o_sum = w_full[DATA_W-1:0];
            o_sat = 1'b0;
        end
    end
`else
    // Plain wrapping add; saturation never reported
    always_comb begin
        o_sum = i_a + i_b;
        o_sat = 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/fib_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fib_ram_ctrl
// Description : Sequencer in front of a single-port sync-read RAM. On start it
//               computes mem[i] = mem[i-2] + mem[i-1] for i = 2..LAST_ADDR,
//               four cycles per element, and pulses done after the last write.
//               Optional macro FIB_SAT_EN: saturating add with sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_ram_ctrl
    import fib_ram_ctrl_pkg::*;
#(
    parameter int DATA_W    = c_data_w_def,
    parameter int ADDR_W    = c_addr_w_def,
    parameter int LAST_ADDR = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_two  = ADDR_W'(2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              r_ovf;
    logic [DATA_W-1:0] w_sum;
    logic              w_sat;

    fib_add_sat #(
        .DATA_W (DATA_W)
    ) u_add (
        .i_a   (r_data1),
        .i_b   (r_data2),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    // State register; reset aborts any run back to idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM-side outputs decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_rd_a;
                end
            end
            c_st_rd_a: begin
                ram_addr    = r_idx - c_two;
                w_state_nxt = c_st_rd_b;
            end
            c_st_rd_b: begin
                ram_addr    = r_idx - c_one;
                w_state_nxt = c_st_cap_b;
            end
            c_st_cap_b: begin
                w_state_nxt = c_st_wr;
            end
            c_st_wr: begin
                ram_addr    = r_idx;
                ram_we      = 1'b1;
                ram_wdata   = w_sum;
                w_state_nxt = (r_idx == c_last) ? c_st_fin : c_st_rd_a;
            end
            c_st_fin: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Index, operand capture and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= c_two;
            r_data1 <= '0;
            r_data2 <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_idx <= c_two;
                        r_ovf <= 1'b0;
                    end
                end
                c_st_rd_b:  r_data1 <= ram_rdata;
                c_st_cap_b: r_data2 <= ram_rdata;
                c_st_wr: begin
                    if (r_idx != c_last) begin
                        r_idx <= r_idx + c_one;
                    end
                    if (w_sat) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data1 = r_data1;
    assign data2 = r_data2;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fib_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_ram_ctrl
// Description : Directed self-checking bench for fib_ram_ctrl. Three
//               instances: A (32b, LAST_ADDR=9), B (32b, LAST_ADDR=2),
//               C (8b, LAST_ADDR=2), each with its own sync-read RAM model.
//               Expectations for C follow macro FIB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic        start_a, busy_a, done_a, ovf_a, we_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a, rdata_a, d1_a, d2_a;
    logic        start_b, busy_b, done_b, ovf_b, we_b;
    logic [5:0]  addr_b;
    logic [31:0] wdata_b, rdata_b, d1_b, d2_b;
    logic        start_c, busy_c, done_c, ovf_c, we_c;
    logic [5:0]  addr_c;
    logic [7:0]  wdata_c, rdata_c, d1_c, d2_c;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [7:0]  mem_c [0:63];

    logic        ld_en;
    logic [1:0]  ld_sel;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    logic [5:0]  exp_addr_a;
    int          wcnt_b;

    fib_ram_ctrl #(.DATA_W(32), .ADDR_W(6), .LAST_ADDR(9)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .ovf(ovf_a), .ram_addr(addr_a), .ram_we(we_a), .ram_wdata(wdata_a),
        .ram_rdata(rdata_a), .data1(d1_a), .data2(d2_a));

    fib_ram_ctrl #(.DATA_W(32), .ADDR_W(6), .LAST_ADDR(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .ovf(ovf_b), .ram_addr(addr_b), .ram_we(we_b), .ram_wdata(wdata_b),
        .ram_rdata(rdata_b), .data1(d1_b), .data2(d2_b));

    fib_ram_ctrl #(.DATA_W(8), .ADDR_W(6), .LAST_ADDR(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .ovf(ovf_c), .ram_addr(addr_c), .ram_we(we_c), .ram_wdata(wdata_c),
        .ram_rdata(rdata_c), .data1(d1_c), .data2(d2_c));

    // RAM models: bench preload port has priority, sync read
    always @(posedge clk) begin
        if (ld_en && ld_sel == 2'd0) mem_a[ld_addr] <= ld_data;
        else if (we_a)               mem_a[addr_a]  <= wdata_a;
        rdata_a <= mem_a[addr_a];
        if (ld_en && ld_sel == 2'd1) mem_b[ld_addr] <= ld_data;
        else if (we_b)               mem_b[addr_b]  <= wdata_b;
        rdata_b <= mem_b[addr_b];
        if (ld_en && ld_sel == 2'd2) mem_c[ld_addr] <= ld_data[7:0];
        else if (we_c)               mem_c[addr_c]  <= wdata_c;
        rdata_c <= mem_c[addr_c];
    end

    task automatic load(input int sel, input int addr, input logic [31:0] d);
        ld_sel  = 2'(sel);
        ld_addr = 6'(addr);
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic seed(input int sel, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] fill);
        @(negedge clk);
        load(sel, 0, s0);
        load(sel, 1, s1);
        for (int k = 2; k < 64; k++) load(sel, k, fill);
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulse start and count rising edges until done; n=-1 on timeout
    task automatic run(input int sel, input int limit, output int n);
        logic d;
        @(negedge clk);
        if (sel == 0) exp_addr_a = 6'd2;
        set_start(sel, 1'b1);
        n = -1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #1;
            set_start(sel, 1'b0);
            case (sel)
                0:       d = done_a;
                1:       d = done_b;
                default: d = done_c;
            endcase
            if (d) begin
                n = k + 1;
                break;
            end
        end
    endtask

    // Continuous watch of instance A writes and instance B write count
    task automatic test_monitor();
        logic        prev_we = 1'b0;
        int          gap = 0;
        logic [31:0] ea, eb;
        forever begin
            @(negedge clk);
            gap++;
            if (rst_n === 1'b1 && we_a === 1'b1) begin
                ea = mem_a[addr_a - 6'd2];
                eb = mem_a[addr_a - 6'd1];
                total++;
                if (prev_we !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_back_to_back_we: actual prev_we=%b required 0", prev_we);
                end
                total++;
                if (addr_a !== exp_addr_a) begin
                    bad++;
                    $display("FAIL mon_wr_addr: actual %0d required %0d", addr_a, exp_addr_a);
                end
                if (exp_addr_a != 6'd2) begin
                    total++;
                    if (gap !== 4) begin
                        bad++;
                        $display("FAIL mon_wr_spacing: actual %0d required 4", gap);
                    end
                end
                total++;
                if (d1_a !== ea) begin
                    bad++;
                    $display("FAIL mon_data1: actual %h required %h", d1_a, ea);
                end
                total++;
                if (d2_a !== eb) begin
                    bad++;
                    $display("FAIL mon_data2: actual %h required %h", d2_a, eb);
                end
                total++;
                if (wdata_a !== ea + eb) begin
                    bad++;
                    $display("FAIL mon_wdata: actual %h required %h", wdata_a, ea + eb);
                end
                exp_addr_a = exp_addr_a + 6'd1;
                gap = 0;
            end
            prev_we = we_a;
            if (rst_n === 1'b1 && we_b === 1'b1) wcnt_b++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (addr_a !== 6'd0)  begin bad++; $display("FAIL rst_addr: actual %h required 0", addr_a); end
        total++; if (we_a !== 1'b0)    begin bad++; $display("FAIL rst_we: actual %b required 0", we_a); end
        total++; if (wdata_a !== 32'd0) begin bad++; $display("FAIL rst_wdata: actual %h required 0", wdata_a); end
        total++; if (d1_a !== 32'd0)   begin bad++; $display("FAIL rst_data1: actual %h required 0", d1_a); end
        total++; if (d2_a !== 32'd0)   begin bad++; $display("FAIL rst_data2: actual %h required 0", d2_a); end
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL rst_busy: actual %b required 0", busy_a); end
        total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL rst_done: actual %b required 0", done_a); end
        total++; if (ovf_a !== 1'b0)   begin bad++; $display("FAIL rst_ovf: actual %b required 0", ovf_a); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fib9();
        int          n;
        logic [31:0] exp9 [0:7];
        exp9 = '{32'h4, 32'h6, 32'ha, 32'h10, 32'h1a, 32'h2a, 32'h44, 32'h6e};
        seed(0, 32'd2, 32'd2, 32'hdeadbeef);
        run(0, 200, n);
        total++; if (n !== 33) begin bad++; $display("FAIL fib9_latency: actual %0d required 33", n); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL fib9_busy_at_done: actual %b required 0", busy_a); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (mem_a[k+2] !== exp9[k]) begin
                bad++;
                $display("FAIL fib9_mem%0d: actual %h required %h", k + 2, mem_a[k+2], exp9[k]);
            end
        end
        total++; if (mem_a[10] !== 32'hdeadbeef) begin bad++; $display("FAIL fib9_mem10: actual %h required deadbeef", mem_a[10]); end
        @(posedge clk);
        #1;
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL fib9_done_width: actual %b required 0", done_a); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (d1_a !== 32'h2a) begin bad++; $display("FAIL fib9_data1_hold: actual %h required 2a", d1_a); end
        total++; if (d2_a !== 32'h44) begin bad++; $display("FAIL fib9_data2_hold: actual %h required 44", d2_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL fib9_busy_idle: actual %b required 0", busy_a); end
    endtask

    task automatic test_last2();
        int n;
        seed(1, 32'd0, 32'd1, 32'hdeadbeef);
        wcnt_b = 0;
        run(1, 50, n);
        total++; if (n !== 5) begin bad++; $display("FAIL last2_latency: actual %0d required 5", n); end
        total++; if (mem_b[2] !== 32'd1) begin bad++; $display("FAIL last2_mem2: actual %h required 1", mem_b[2]); end
        total++; if (mem_b[3] !== 32'hdeadbeef) begin bad++; $display("FAIL last2_mem3: actual %h required deadbeef", mem_b[3]); end
        @(posedge clk);
        #1;
        total++; if (wcnt_b !== 1) begin bad++; $display("FAIL last2_writes: actual %0d required 1", wcnt_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL last2_busy_after: actual %b required 0", busy_b); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL last2_done_after: actual %b required 0", done_b); end
    endtask

    task automatic test_start_ignored();
        int n;
        seed(0, 32'd2, 32'd2, 32'hdeadbeef);
        @(negedge clk);
        exp_addr_a = 6'd2;
        start_a = 1'b1;
        n = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            start_a = (k + 1 == 5);
            if (done_a) begin
                n = k + 1;
                break;
            end
        end
        total++; if (n !== 33) begin bad++; $display("FAIL busy_start_latency: actual %0d required 33", n); end
        total++; if (mem_a[5] !== 32'h10) begin bad++; $display("FAIL busy_start_mem5: actual %h required 10", mem_a[5]); end
        total++; if (mem_a[9] !== 32'h6e) begin bad++; $display("FAIL busy_start_mem9: actual %h required 6e", mem_a[9]); end
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL fin_start_busy: actual %b required 0", busy_a); end
        @(posedge clk);
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL fin_start_busy2: actual %b required 0", busy_a); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int dcnt  = 0;
        seed(0, 32'd2, 32'd2, 32'hdeadbeef);
        @(negedge clk);
        exp_addr_a = 6'd2;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (we_a && addr_a == 6'd4) begin
                found = 1;
                break;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL midrst_reach_wr4: actual %b required 1", found); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (we_a !== 1'b0)     begin bad++; $display("FAIL midrst_we: actual %b required 0", we_a); end
        total++; if (addr_a !== 6'd0)   begin bad++; $display("FAIL midrst_addr: actual %h required 0", addr_a); end
        total++; if (busy_a !== 1'b0)   begin bad++; $display("FAIL midrst_busy: actual %b required 0", busy_a); end
        total++; if (d1_a !== 32'd0)    begin bad++; $display("FAIL midrst_data1: actual %h required 0", d1_a); end
        total++; if (d2_a !== 32'd0)    begin bad++; $display("FAIL midrst_data2: actual %h required 0", d2_a); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_a) dcnt++;
        end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL midrst_no_done: actual %0d required 0", dcnt); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst_stays_idle: actual %b required 0", busy_a); end
        total++; if (mem_a[4] !== 32'ha) begin bad++; $display("FAIL midrst_mem4: actual %h required a", mem_a[4]); end
        for (int k = 5; k < 10; k++) begin
            total++;
            if (mem_a[k] !== 32'hdeadbeef) begin
                bad++;
                $display("FAIL midrst_mem%0d: actual %h required deadbeef", k, mem_a[k]);
            end
        end
    endtask

    task automatic test_ovf();
        int         n;
`ifdef FIB_SAT_EN
        logic [7:0] exp_sum = 8'hff;
        logic       exp_ovf = 1'b1;
`else
        logic [7:0] exp_sum = 8'h00;
        logic       exp_ovf = 1'b0;
`endif
        seed(2, 32'h80, 32'h80, 32'h55);
        run(2, 50, n);
        total++; if (n !== 5) begin bad++; $display("FAIL ovf_latency: actual %0d required 5", n); end
        total++; if (mem_c[2] !== exp_sum) begin bad++; $display("FAIL ovf_mem2: actual %h required %h", mem_c[2], exp_sum); end
        total++; if (ovf_c !== exp_ovf) begin bad++; $display("FAIL ovf_flag: actual %b required %b", ovf_c, exp_ovf); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (ovf_c !== exp_ovf) begin bad++; $display("FAIL ovf_sticky: actual %b required %b", ovf_c, exp_ovf); end
        seed(2, 32'h01, 32'h01, 32'h55);
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        total++; if (ovf_c !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: actual %b required 0", ovf_c); end
        n = -1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (done_c) begin
                n = k + 2;
                break;
            end
        end
        total++; if (n !== 5) begin bad++; $display("FAIL ovf_rerun_latency: actual %0d required 5", n); end
        total++; if (mem_c[2] !== 8'h02) begin bad++; $display("FAIL ovf_rerun_mem2: actual %h required 02", mem_c[2]); end
        total++; if (ovf_c !== 1'b0) begin bad++; $display("FAIL ovf_rerun_flag: actual %b required 0", ovf_c); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        start_c    = 1'b0;
        ld_en      = 1'b0;
        ld_sel     = 2'd0;
        ld_addr    = 6'd0;
        ld_data    = 32'd0;
        exp_addr_a = 6'd2;
        wcnt_b     = 0;
        fork
            test_monitor();
        join_none
        test_reset();
        test_fib9();
        test_last2();
        test_start_ignored();
        test_reset_mid();
        test_ovf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
